program_loader: RTL and testbench

- Byte-stream bootloader. It is the writer side of the CPU's instruction-fetch path: the CPU only reads program memory, and this block fills it.
- It receives a framed program image over an 8-bit valid/ready stream, assembles 14-bit instruction words and writes them sequentially into program memory from address 0.
- While loading, it holds the CPU in reset through cpu_hold. It releases the CPU only after a complete frame passes checksum.

---
 rtl/program_loader_pkg.sv | 29 ++
 rtl/loader_checksum_acc.sv | 35 +++
 rtl/program_loader.sv | 163 ++++++++++++++++
 tb/tb_program_loader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: size defaults, frame marker,
// FSM state encoding and the program-memory write payload.
package program_loader_pkg;

  localparam int unsigned DEF_ADDR_W    = 11;
  localparam int unsigned DEF_DATA_W    = 14;
  localparam logic [7:0]  DEF_SYNC_BYTE = 8'hA5;
  localparam int unsigned MAX_WORDS     = 2048;
  localparam int unsigned STATE_W       = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 4'd0,
    CNT_H = 4'd1,
    CNT_L = 4'd2,
    W_HI  = 4'd3,
    W_LO  = 4'd4,
    WRITE = 4'd5,
    CHK   = 4'd6,
    DONE  = 4'd7,
    ERR   = 4'd8
  } state_t;

  // One program-memory write at the default geometry.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } prog_wr_t;

endpackage

// File: rtl/loader_checksum_acc.sv
// 8-bit clearable running sum of frame bytes.
// Ports:
//   clk, reset   - clock, async active-low reset
//   clr          - zero the sum (takes priority over add)
//   add          - add data into the sum this cycle
//   data         - byte being accumulated
//   sum_zero_c   - combinational: (sum + data) mod 256 == 0, i.e. the frame
//                  checksums to zero if data is the final byte
module loader_checksum_acc (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       add,
  input  logic [7:0] data,
  output logic       sum_zero_c
);

  logic [7:0] sum_q;
  logic [7:0] sum_next;

  assign sum_next   = sum_q + data;
  assign sum_zero_c = (sum_next == 8'd0);

  // Running sum register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= 8'd0;
    end else if (clr) begin
      sum_q <= 8'd0;
    end else if (add) begin
      sum_q <= sum_next;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Byte-stream bootloader: parses a framed program image from an 8-bit
// valid/ready stream, writes 14-bit words sequentially into program memory
// from address 0 and holds the CPU in reset until a frame verifies.
// Ports:
//   clk, reset            - clock, async active-low reset
//   in_data/in_valid      - stream byte and its valid
//   in_ready              - byte accepted when in_valid && in_ready
//   prog_we/addr/data     - single-cycle program memory write
//   cpu_hold              - 1 keeps the CPU in reset
//   done / error          - last frame verified / rejected
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter logic [7:0]  SYNC_BYTE = DEF_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [DATA_W-1:0] prog_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  // Counter is one bit wider than the address so N == 2**ADDR_W fits.
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned HI_W  = DATA_W - 8;

  state_t            state_q;
  state_t            state_d;
  logic              xfer_c;
  logic              acc_clr;
  logic              acc_add;
  logic              sum_zero_c;
  logic [3:0]        cnt_hi_q;
  logic [CNT_W-1:0]  word_n_q;
  logic [CNT_W-1:0]  word_cnt_q;
  logic [CNT_W-1:0]  n_c;

  assign xfer_c = in_valid && in_ready;
  assign n_c    = CNT_W'({cnt_hi_q, in_data});

  loader_checksum_acc u_acc (
    .clk        (clk),
    .reset      (reset),
    .clr        (acc_clr),
    .add        (acc_add),
    .data       (in_data),
    .sum_zero_c (sum_zero_c)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and accumulator control
  always_comb begin
    state_d = state_q;
    acc_clr = 1'b0;
    acc_add = 1'b0;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (xfer_c && (in_data == SYNC_BYTE)) begin
          state_d = CNT_H;
          acc_clr = 1'b1;
        end
      end
      CNT_H: begin
        if (xfer_c) begin
          acc_add = 1'b1;
          state_d = (in_data[7:4] != 4'd0) ? ERR : CNT_L;
        end
      end
      CNT_L: begin
        if (xfer_c) begin
          acc_add = 1'b1;
          if ((n_c == '0) || (n_c > CNT_W'(MAX_WORDS))) begin
            state_d = ERR;
          end else begin
            state_d = W_HI;
          end
        end
      end
      W_HI: begin
        if (xfer_c) begin
          acc_add = 1'b1;
          state_d = (in_data[7:6] != 2'd0) ? ERR : W_LO;
        end
      end
      W_LO: begin
        if (xfer_c) begin
          acc_add = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = ((word_cnt_q + CNT_W'(1)) == word_n_q) ? CHK : W_HI;
      end
      CHK: begin
        if (xfer_c) begin
          acc_add = 1'b1;
          state_d = sum_zero_c ? DONE : ERR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs (decoded from next state) and datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready   <= 1'b1;
      prog_we    <= 1'b0;
      prog_addr  <= '0;
      prog_data  <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      cnt_hi_q   <= 4'd0;
      word_n_q   <= '0;
      word_cnt_q <= '0;
    end else begin
      in_ready <= (state_d != WRITE);
      prog_we  <= (state_d == WRITE);
      cpu_hold <= (state_d != DONE);
      done     <= (state_d == DONE);
      error    <= (state_d == ERR);

      if (acc_clr) begin
        word_cnt_q <= '0;
        prog_addr  <= '0;
      end

      if (xfer_c) begin
        unique case (state_q)
          CNT_H:   cnt_hi_q <= in_data[3:0];
          CNT_L:   word_n_q <= n_c;
          W_HI:    prog_data[DATA_W-1:8] <= in_data[HI_W-1:0];
          W_LO:    prog_data[7:0] <= in_data;
          default: ;
        endcase
      end

      // Address wraps naturally at 2**ADDR_W after a full-size image.
      if (state_q == WRITE) begin
        prog_addr  <= prog_addr + ADDR_W'(1);
        word_cnt_q <= word_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames plus randomized
// frames, checked against a frame-parsing reference model.
module tb_program_loader;
  import program_loader_pkg::*;

  typedef logic [7:0] bq_t[$];

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [7:0]            in_data = 8'd0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic                  prog_we;
  logic [DEF_ADDR_W-1:0] prog_addr;
  logic [DEF_DATA_W-1:0] prog_data;
  logic                  cpu_hold;
  logic                  done;
  logic                  error;

  int vectors = 0;
  int miscompares = 0;

  prog_wr_t obs_q[$];
  prog_wr_t exp_q[$];
  int       viol_excl = 0;
  int       viol_pulse = 0;
  logic     we_prev = 1'b0;

  logic m_done = 1'b0;
  logic m_err  = 1'b0;
  int   m_addr = 0;

  always #5 clk = ~clk;

  program_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  // Write capture and handshake invariants
  always @(negedge clk) begin
    if (!reset) begin
      we_prev = 1'b0;
    end else begin
      if (prog_we) obs_q.push_back(prog_wr_t'({prog_addr, prog_data}));
      if (prog_we && in_ready) viol_excl++;
      if (prog_we && we_prev) viol_pulse++;
      we_prev = prog_we;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] garb();
    logic [7:0] b;
    do b = 8'($urandom); while (b == DEF_SYNC_BYTE);
    return b;
  endfunction

  // Offer one byte, hold it until accepted (bounded)
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) break;
      if (t > 20) begin
        check("hs_timeout", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  // Reference model: parse complete frames from the accepted byte stream
  task automatic model_stream(input bq_t s);
    int i, n, sum;
    logic [7:0] h, l, c;
    logic ok;
    i = 0;
    while (i < s.size()) begin
      if (s[i] != DEF_SYNC_BYTE) begin
        i++;
        continue;
      end
      i++;
      m_done = 1'b0; m_err = 1'b0; m_addr = 0;
      h = s[i++];
      sum = int'(h);
      if (h[7:4] != 4'd0) begin m_err = 1'b1; continue; end
      l = s[i++];
      sum += int'(l);
      n = int'(h) * 256 + int'(l);
      if (n == 0 || n > MAX_WORDS) begin m_err = 1'b1; continue; end
      ok = 1'b1;
      for (int w = 0; w < n; w++) begin
        h = s[i++];
        sum += int'(h);
        if (h[7:6] != 2'd0) begin ok = 1'b0; break; end
        l = s[i++];
        sum += int'(l);
        exp_q.push_back(prog_wr_t'({11'(m_addr), h[5:0], l}));
        m_addr = (m_addr + 1) % MAX_WORDS;
      end
      if (!ok) begin m_err = 1'b1; continue; end
      c = s[i++];
      sum += int'(c);
      if (sum % 256 == 0) m_done = 1'b1;
      else m_err = 1'b1;
    end
  endtask

  task automatic compare_all();
    int n;
    check("n_writes", 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check("wr_addr", 32'(obs_q[i].addr), 32'(exp_q[i].addr));
      check("wr_data", 32'(obs_q[i].data), 32'(exp_q[i].data));
    end
    check("done", 32'(done), 32'(m_done));
    check("error", 32'(error), 32'(m_err));
    check("cpu_hold", 32'(cpu_hold), 32'(!m_done));
    check("prog_addr", 32'(prog_addr), 32'(m_addr));
    check("rdy_we_excl", 32'(viol_excl), 32'd0);
    check("we_pulse", 32'(viol_pulse), 32'd0);
    obs_q.delete(); exp_q.delete();
    viol_excl = 0; viol_pulse = 0;
  endtask

  // gmode: 0 back-to-back, 1 valid toggles, 2 random gaps
  task automatic run_stream(input bq_t s, input int gmode);
    int gap;
    foreach (s[i]) begin
      gap = (gmode == 1) ? 1 :
            (gmode == 2 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      send_byte(s[i], gap);
    end
    in_valid = 1'b0;
    model_stream(s);
    repeat (2) begin @(posedge clk); #1; end
    compare_all();
  endtask

  // kind: 0 good, 1 bad chk, 2 bad hi bits, 3 bad count nibble,
  //       4 zero count, 5 count > max, 6 good with leading garbage
  task automatic make_frame(input int n, input int kind, output bq_t s);
    int sum, bad;
    logic [7:0] h, l, chk;
    s = {};
    if (kind == 6) repeat ($urandom_range(1, 3)) s.push_back(garb());
    s.push_back(DEF_SYNC_BYTE);
    if (kind == 3) begin
      s.push_back(8'($urandom_range(16, 255)));
      repeat ($urandom_range(0, 3)) s.push_back(garb());
      return;
    end
    if (kind == 4) begin
      s.push_back(8'd0); s.push_back(8'd0);
      repeat ($urandom_range(0, 3)) s.push_back(garb());
      return;
    end
    if (kind == 5) begin
      h = 8'($urandom_range(8, 15));
      l = (h == 8'd8) ? 8'($urandom_range(1, 255)) : 8'($urandom_range(0, 255));
      s.push_back(h); s.push_back(l);
      repeat ($urandom_range(0, 3)) s.push_back(garb());
      return;
    end
    s.push_back(8'(n >> 8));
    s.push_back(8'(n & 255));
    sum = (n >> 8) + (n & 255);
    bad = (kind == 2) ? int'($urandom_range(0, n - 1)) : -1;
    for (int w = 0; w < n; w++) begin
      h = 8'($urandom_range(0, 63));
      l = 8'($urandom_range(0, 255));
      if (w == bad) begin
        h = h | (($urandom_range(0, 1) == 1) ? 8'h40 : 8'h80);
        s.push_back(h);
        repeat ($urandom_range(0, 3)) s.push_back(garb());
        return;
      end
      s.push_back(h); s.push_back(l);
      sum += int'(h) + int'(l);
    end
    chk = 8'((256 - sum % 256) % 256);
    if (kind == 1) chk = 8'((int'(chk) + int'($urandom_range(1, 255))) % 256);
    s.push_back(chk);
    repeat ($urandom_range(0, 2)) s.push_back(garb());
  endtask

  initial begin
    bq_t s;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_prog_we", 32'(prog_we), 32'd0);
    check("rst_prog_addr", 32'(prog_addr), 32'd0);
    check("rst_prog_data", 32'(prog_data), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Two-word load, then bad checksum
    s = {8'hA5, 8'h00, 8'h02, 8'h30, 8'h05, 8'h00, 8'h8D, 8'h3C};
    run_stream(s, 0);
    check("tp1_done", 32'(done), 32'd1);
    s = {8'hA5, 8'h00, 8'h02, 8'h30, 8'h05, 8'h00, 8'h8D, 8'h3D};
    run_stream(s, 0);
    check("tp2_error", 32'(error), 32'd1);

    // Bad HI bits, then discarded bytes
    s = {8'hA5, 8'h00, 8'h01, 8'h40, 8'h8D, 8'h72, 8'h11};
    run_stream(s, 0);

    // Zero count, over-range count, then a one-word load
    s = {8'hA5, 8'h00, 8'h00};
    run_stream(s, 0);
    s = {8'hA5, 8'h08, 8'h01};
    run_stream(s, 0);
    s = {8'hA5, 8'h00, 8'h01, 8'h00, 8'h8D, 8'h72};
    run_stream(s, 0);
    check("tp4_done", 32'(done), 32'd1);

    // Backpressure: valid toggling through a 3-word frame
    make_frame(3, 0, s);
    run_stream(s, 1);

    // Abort after first word's HI byte
    s = {8'hA5, 8'h00, 8'h02, 8'h30};
    foreach (s[i]) send_byte(s[i], 0);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("abort_prog_we", 32'(prog_we), 32'd0);
    check("abort_prog_addr", 32'(prog_addr), 32'd0);
    check("abort_prog_data", 32'(prog_data), 32'd0);
    check("abort_cpu_hold", 32'(cpu_hold), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_error", 32'(error), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    m_done = 1'b0; m_err = 1'b0; m_addr = 0;
    obs_q.delete(); exp_q.delete();
    viol_excl = 0; viol_pulse = 0;
    make_frame(4, 0, s);
    run_stream(s, 2);

    // Randomized frames
    for (int k = 0; k < 40; k++) begin
      make_frame(int'($urandom_range(1, 5)), int'($urandom_range(0, 6)), s);
      run_stream(s, 2);
    end

    // Full-size image: address wraps back to 0
    make_frame(MAX_WORDS, 0, s);
    run_stream(s, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
